// File: rtl/lcfg_cfgo_master.sv
// TV80 I/O-mapped config-bus master: 16-byte window, one bus transaction per launch, with timeout.
// Optional feature: define LCFG_CFGO_AUTOINC_EN for status bit7 address auto-increment.
module lcfg_cfgo_master #(
    parameter logic [15:0] io_base_addr = 16'h0000,
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 16,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   addr,
    input  logic [7:0]    cd_wdata,
    output logic [7:0]    cd_rdata,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    output logic          cfgo_wait_n,
    output logic          cfgo_irdy,
    input  logic          cfgo_trdy,
    output logic [AW-1:0] cfgo_addr,
    output logic          cfgo_write,
    output logic [DW-1:0] cfgo_wr_data,
    input  logic [DW-1:0] cfgo_rd_data,
    output logic          cfgo_err
);
    localparam int unsigned DB = DW / 8;
    localparam int unsigned AB = AW / 8;

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StAck} state_e;

    state_e        state_q;
    logic          done_q;
    logic [DW-1:0] hold_q;
    logic [AW-1:0] addr_q;
    logic          timeout_q;
    logic          autoinc_q;
    logic [15:0]   cnt_q;

    logic          hit, rd_acc, wr_acc, rd_off0, busy, acc, launch_rd;
    logic [3:0]    off;
    logic [7:0]    status, rbyte;
    logic [DW-1:0] hold_wr;
    logic          unused_addr;

    assign unused_addr = ^addr[15:8];

    assign off       = addr[3:0];
    assign hit       = !iorq_n && mreq_n && (!rd_n || !wr_n) && (addr[7:4] == io_base_addr[7:4]);
    assign rd_acc    = !rd_n;
    assign wr_acc    = !wr_n && rd_n;
    assign rd_off0   = hit && rd_acc && (off == 4'd0);
    assign busy      = (state_q != StIdle);
    assign status    = {autoinc_q, 5'b0, timeout_q, busy};
    assign cfgo_addr = addr_q;
    assign cfgo_err  = timeout_q;

    // Anything hitting the window while a transaction is in flight is held off; only the
    // read of offset 0 that started a read is released once the data sits in ACK.
    always_comb begin
        if (!hit || done_q)         cfgo_wait_n = 1'b1;
        else if (state_q == StAck)  cfgo_wait_n = rd_off0;
        else if (busy)              cfgo_wait_n = 1'b0;
        else                        cfgo_wait_n = !rd_off0;
    end

    assign acc       = hit && !done_q && cfgo_wait_n;
    assign launch_rd = hit && !done_q && !busy && rd_off0;

    always_comb begin
        rbyte = 8'h00;
        for (int i = 0; i < int'(DB); i++) begin
            if (off == 4'(i)) rbyte = hold_q[8*i +: 8];
        end
        for (int i = 0; i < int'(AB); i++) begin
            if (off == 4'(8 + i)) rbyte = addr_q[8*i +: 8];
        end
        if (off == 4'd12) rbyte = status;
        cd_rdata = (hit && rd_acc) ? rbyte : 8'h00;
    end

    always_comb begin
        hold_wr = hold_q;
        for (int i = 0; i < int'(DB); i++) begin
            if (off == 4'(i)) hold_wr[8*i +: 8] = cd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            done_q       <= 1'b0;
            hold_q       <= '0;
            addr_q       <= '0;
            timeout_q    <= 1'b0;
            autoinc_q    <= 1'b0;
            cnt_q        <= '0;
            cfgo_irdy    <= 1'b0;
            cfgo_write   <= 1'b0;
            cfgo_wr_data <= '0;
        end else begin
            if (!hit)     done_q <= 1'b0;
            else if (acc) done_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (acc && wr_acc) begin
                        if (off < 4'(DB)) begin
                            hold_q <= hold_wr;
                            if (off == 4'(DB - 1)) begin
                                state_q      <= StWrite;
                                cfgo_irdy    <= 1'b1;
                                cfgo_write   <= 1'b1;
                                cfgo_wr_data <= hold_wr;
                                cnt_q        <= '0;
                            end
                        end
                        for (int i = 0; i < int'(AB); i++) begin
                            if (off == 4'(8 + i)) addr_q[8*i +: 8] <= cd_wdata;
                        end
                        if (off == 4'd12) begin
                            if (cd_wdata[1]) timeout_q <= 1'b0;
`ifdef LCFG_CFGO_AUTOINC_EN
                            autoinc_q <= cd_wdata[7];
`endif
                        end
                    end else if (launch_rd) begin
                        state_q    <= StRead;
                        cfgo_irdy  <= 1'b1;
                        cfgo_write <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                StWrite, StRead: begin
                    // trdy is checked first so a response on the last allowed cycle is not an error
                    if (cfgo_trdy) begin
                        cfgo_irdy <= 1'b0;
                        if (state_q == StRead) begin
                            hold_q  <= cfgo_rd_data;
                            state_q <= StAck;
                        end else begin
                            state_q <= StIdle;
                        end
`ifdef LCFG_CFGO_AUTOINC_EN
                        if (autoinc_q) addr_q <= addr_q + AW'(DB);
`endif
                    end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        cfgo_irdy <= 1'b0;
                        timeout_q <= 1'b1;
                        if (state_q == StRead) begin
                            hold_q  <= '1;
                            state_q <= StAck;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StAck: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lcfg_cfgo_master.sv
// Self-checking bench for lcfg_cfgo_master: CPU access tasks, a target responder and a scoreboard.
`timescale 1ns/1ps
module tb_lcfg_cfgo_master;
    localparam logic [15:0] BASE = 16'h0040;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   addr;
    logic [7:0]    cd_wdata;
    logic [7:0]    cd_rdata;
    logic          mreq_n, iorq_n, rd_n, wr_n;
    logic          cfgo_wait_n, cfgo_irdy, cfgo_write, cfgo_err;
    logic          cfgo_trdy = 1'b0;
    logic [AW-1:0] cfgo_addr;
    logic [DW-1:0] cfgo_wr_data;
    logic [DW-1:0] cfgo_rd_data = '0;

    lcfg_cfgo_master #(
        .io_base_addr(BASE),
        .DW(DW),
        .AW(AW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .addr(addr),
        .cd_wdata(cd_wdata),
        .cd_rdata(cd_rdata),
        .mreq_n(mreq_n),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .cfgo_wait_n(cfgo_wait_n),
        .cfgo_irdy(cfgo_irdy),
        .cfgo_trdy(cfgo_trdy),
        .cfgo_addr(cfgo_addr),
        .cfgo_write(cfgo_write),
        .cfgo_wr_data(cfgo_wr_data),
        .cfgo_rd_data(cfgo_rd_data),
        .cfgo_err(cfgo_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } tx_t;

    tx_t        got_tx[$];
    tx_t        exp_tx[$];
    logic [7:0] exp_rd[$];
    int         n_vec = 0;
    int         n_mis = 0;

    bit            tgt_en = 1'b0;
    bit            tgt_force = 1'b0;
    int            tgt_delay = 0;
    logic [DW-1:0] tgt_rdata = '0;
    int            irdy_cnt = 0;
    int            irdy_run = 0;
    int            last_len = 0;

    // Target: answers the (tgt_delay+1)-th cycle of each request and logs what it saw.
    always @(negedge clk) begin
        if (cfgo_irdy) begin
            irdy_run++;
        end else begin
            if (irdy_run > 0) last_len = irdy_run;
            irdy_run = 0;
        end
        if (cfgo_irdy && tgt_en) begin
            if (irdy_cnt == tgt_delay) begin
                cfgo_trdy    = 1'b1;
                cfgo_rd_data = tgt_rdata;
                got_tx.push_back(tx_t'{cfgo_write, cfgo_addr, cfgo_wr_data});
            end else begin
                cfgo_trdy = 1'b0;
            end
            irdy_cnt++;
        end else begin
            cfgo_trdy = tgt_force;
            irdy_cnt  = 0;
        end
    end

    function automatic logic [7:0] win(input logic [3:0] o);
        return {BASE[7:4], o};
    endfunction

    task automatic io_access(input bit is_wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output int stalls);
        @(negedge clk);
        addr     = {8'h00, a};
        cd_wdata = wd;
        iorq_n   = 1'b0;
        mreq_n   = 1'b1;
        rd_n     = is_wr;
        wr_n     = !is_wr;
        stalls   = 0;
        #1;
        while (!cfgo_wait_n && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!cfgo_wait_n) begin
            n_vec++;
            n_mis++;
            $display("FAIL wait_bound: wait_n low after %0d cycles, required high", stalls);
        end
        rd = cd_rdata;
        @(negedge clk);
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (got_tx.size() < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (got_tx.size() < n) begin
            n_vec++;
            n_mis++;
            $display("FAIL tx_bound: %0d transactions seen, required %0d", got_tx.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] r;
        int s;
        #1;
        n_vec += 7;
        if (cfgo_irdy !== 1'b0) begin n_mis++; $display("FAIL rst_irdy: got %b exp 0", cfgo_irdy); end
        if (cfgo_write !== 1'b0) begin n_mis++; $display("FAIL rst_write: got %b exp 0", cfgo_write); end
        if (cfgo_addr !== '0) begin n_mis++; $display("FAIL rst_addr: got %h exp 0", cfgo_addr); end
        if (cfgo_wr_data !== '0) begin n_mis++; $display("FAIL rst_wdata: got %h exp 0", cfgo_wr_data); end
        if (cd_rdata !== 8'h00) begin n_mis++; $display("FAIL rst_rdata: got %h exp 00", cd_rdata); end
        if (cfgo_err !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %b exp 0", cfgo_err); end
        if (cfgo_wait_n !== 1'b1) begin n_mis++; $display("FAIL rst_wait: got %b exp 1", cfgo_wait_n); end
        exp_rd.push_back(8'h00);
        io_access(1'b0, win(4'd12), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL rst_status: got %h exp 00", r); end
    endtask

    task automatic test_write();
        logic [3:0] offs[6] = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [7:0] dats[6] = '{8'h34, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [7:0] r;
        int s;
        tx_t g, e;
        exp_tx.push_back(tx_t'{1'b1, 16'h1234, 32'hDDCCBBAA});
        tgt_en = 1'b1;
        tgt_delay = 0;
        for (int i = 0; i < 6; i++) begin
            io_access(1'b1, win(offs[i]), dats[i], r, s);
            n_vec++;
            if (s !== 0) begin n_mis++; $display("FAIL wr_stall[%0d]: got %0d exp 0", i, s); end
        end
        wait_tx(1);
        repeat (3) @(negedge clk);
        if (got_tx.size() > 0) begin
            g = got_tx.pop_front();
            e = exp_tx.pop_front();
            n_vec++;
            if (g !== e) begin n_mis++; $display("FAIL wr_tx: got %h exp %h", g, e); end
        end
        n_vec++;
        if (last_len !== 1) begin n_mis++; $display("FAIL wr_irdy_len: got %0d exp 1", last_len); end
    endtask

    task automatic test_read();
        logic [7:0] r;
        int s;
        int exp_s[4] = '{4, 0, 0, 0};
        tx_t g;
        tgt_en = 1'b1;
        tgt_delay = 2;
        tgt_rdata = 32'h87654321;
        exp_rd.push_back(8'h21);
        exp_rd.push_back(8'h43);
        exp_rd.push_back(8'h65);
        exp_rd.push_back(8'h87);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            io_access(1'b0, win(4'(i)), 8'h00, r, s);
            e = exp_rd.pop_front();
            n_vec += 2;
            if (r !== e) begin n_mis++; $display("FAIL rd_data[%0d]: got %h exp %h", i, r, e); end
            if (s !== exp_s[i]) begin n_mis++; $display("FAIL rd_stall[%0d]: got %0d exp %0d", i, s, exp_s[i]); end
        end
        if (got_tx.size() > 0) begin
            g = got_tx.pop_front();
            n_vec++;
            if (g.wr !== 1'b0 || g.a !== 16'h1234) begin
                n_mis++;
                $display("FAIL rd_tx: got wr=%b addr=%h exp wr=0 addr=1234", g.wr, g.a);
            end
        end else begin
            n_vec++;
            n_mis++;
            $display("FAIL rd_tx: got none exp one read");
        end
        // Outside the window: no data, no stall, no launch
        @(negedge clk);
        addr = 16'h0050; iorq_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b0;
        #1;
        n_vec += 2;
        if (cd_rdata !== 8'h00) begin n_mis++; $display("FAIL miss_rdata: got %h exp 00", cd_rdata); end
        if (cfgo_wait_n !== 1'b1) begin n_mis++; $display("FAIL miss_wait: got %b exp 1", cfgo_wait_n); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (cfgo_irdy !== 1'b0) begin n_mis++; $display("FAIL miss_launch: irdy got %b exp 0", cfgo_irdy); end
        addr = win(4'd1); mreq_n = 1'b0;
        #1;
        n_vec++;
        if (cd_rdata !== 8'h00) begin n_mis++; $display("FAIL mreq_rdata: got %h exp 00", cd_rdata); end
        @(negedge clk);
        iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic [7:0] r;
        int s;
        tgt_en = 1'b0;
        exp_rd.push_back(8'hFF);
        io_access(1'b0, win(4'd0), 8'h00, r, s);
        n_vec += 2;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL to_data: got %h exp ff", r); end
        if (s !== TO + 1) begin n_mis++; $display("FAIL to_stall: got %0d exp %0d", s, TO + 1); end
        repeat (2) @(negedge clk);
        n_vec += 2;
        if (last_len !== TO) begin n_mis++; $display("FAIL to_irdy_len: got %0d exp %0d", last_len, TO); end
        if (cfgo_err !== 1'b1) begin n_mis++; $display("FAIL to_err: got %b exp 1", cfgo_err); end
        exp_rd.push_back(8'h02);
        io_access(1'b0, win(4'd12), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL to_status: got %h exp 02", r); end
        exp_rd.push_back(8'hFF);
        io_access(1'b0, win(4'd1), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL to_byte1: got %h exp ff", r); end
        io_access(1'b1, win(4'd12), 8'h02, r, s);
        exp_rd.push_back(8'h00);
        io_access(1'b0, win(4'd12), 8'h00, r, s);
        n_vec += 2;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL to_clear: got %h exp 00", r); end
        if (cfgo_err !== 1'b0) begin n_mis++; $display("FAIL to_err_clr: got %b exp 0", cfgo_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        int s;
        tx_t g, e;
        tgt_en = 1'b1;
        tgt_delay = 3;
        exp_tx.push_back(tx_t'{1'b1, 16'h1234, 32'h5AFFFFFF});
        io_access(1'b1, win(4'd3), 8'h5A, r, s);
        n_vec++;
        if (s !== 0) begin n_mis++; $display("FAIL b2b_post: stall got %0d exp 0", s); end
        io_access(1'b1, win(4'd8), 8'h78, r, s);
        n_vec++;
        if (s !== 3) begin n_mis++; $display("FAIL b2b_stall: got %0d exp 3", s); end
        wait_tx(1);
        if (got_tx.size() > 0) begin
            g = got_tx.pop_front();
            e = exp_tx.pop_front();
            n_vec++;
            if (g !== e) begin n_mis++; $display("FAIL b2b_tx: got %h exp %h", g, e); end
        end
        repeat (2) @(negedge clk);
        n_vec += 2;
        if (cfgo_addr !== 16'h1278) begin n_mis++; $display("FAIL b2b_addr: got %h exp 1278", cfgo_addr); end
        if (last_len !== 4) begin n_mis++; $display("FAIL b2b_irdy_len: got %0d exp 4", last_len); end
    endtask

    task automatic test_autoinc();
        logic [7:0] r;
        int s;
        tx_t g, e;
        logic [15:0] a2;
        tgt_en = 1'b1;
        tgt_delay = 0;
        io_access(1'b1, win(4'd8), 8'hFC, r, s);
        io_access(1'b1, win(4'd9), 8'hFF, r, s);
        io_access(1'b1, win(4'd12), 8'h80, r, s);
`ifdef LCFG_CFGO_AUTOINC_EN
        exp_rd.push_back(8'h80);
        a2 = 16'h0000;
`else
        exp_rd.push_back(8'h00);
        a2 = 16'hFFFC;
`endif
        io_access(1'b0, win(4'd12), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL ai_status: got %h", r); end
        exp_tx.push_back(tx_t'{1'b1, 16'hFFFC, 32'h11FFFFFF});
        exp_tx.push_back(tx_t'{1'b1, a2, 32'h22FFFFFF});
        io_access(1'b1, win(4'd3), 8'h11, r, s);
        io_access(1'b1, win(4'd3), 8'h22, r, s);
        wait_tx(2);
        for (int i = 0; i < 2; i++) begin
            if (got_tx.size() > 0) begin
                g = got_tx.pop_front();
                e = exp_tx.pop_front();
                n_vec++;
                if (g !== e) begin n_mis++; $display("FAIL ai_tx[%0d]: got %h exp %h", i, g, e); end
            end
        end
        exp_tx.delete();
        io_access(1'b1, win(4'd12), 8'h00, r, s);
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        int s;
        tgt_en = 1'b0;
        @(negedge clk);
        addr = {8'h00, win(4'd0)}; iorq_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (cfgo_irdy !== 1'b1) begin n_mis++; $display("FAIL rm_irdy_pre: got %b exp 1", cfgo_irdy); end
        reset_n = 1'b0;
        iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (cfgo_irdy !== 1'b0) begin n_mis++; $display("FAIL rm_irdy_post: got %b exp 0", cfgo_irdy); end
        reset_n = 1'b1;
        tgt_force = 1'b1;
        repeat (4) @(negedge clk);
        tgt_force = 1'b0;
        #1;
        n_vec += 2;
        if (cfgo_irdy !== 1'b0) begin n_mis++; $display("FAIL rm_irdy_late: got %b exp 0", cfgo_irdy); end
        if (cfgo_addr !== 16'h0000) begin n_mis++; $display("FAIL rm_addr: got %h exp 0000", cfgo_addr); end
        exp_rd.push_back(8'h00);
        io_access(1'b0, win(4'd12), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL rm_status: got %h exp 00", r); end
        exp_rd.push_back(8'h00);
        io_access(1'b0, win(4'd1), 8'h00, r, s);
        n_vec++;
        if (r !== exp_rd.pop_front()) begin n_mis++; $display("FAIL rm_hold: got %h exp 00", r); end
    endtask

    initial begin
        reset_n  = 1'b0;
        addr     = 16'h0000;
        cd_wdata = 8'h00;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_autoinc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lcfg_cfgo_master.md
# lcfg_cfgo_master

Parametrised TV80 I/O-mapped configuration-bus master, successor of the fixed 16-bit-address / 32-bit-data config driver in the app_localcfg subsystem. It presents a 16-byte I/O window to the TV80 and converts byte accesses into single config-bus transactions of configurable address and data width. It adds a bus timeout with a sticky error flag, a status register, and back-pressure to the CPU while a transaction is outstanding.

## Interface
- io_base_addr, 0: I/O base; bits [3:0] must be 0; window is io_base_addr..io_base_addr+15
- DW, 32: config data width; multiple of 8, 8..64
- AW, 16: config address width; multiple of 8, 8..32
- TIMEOUT, 255: cycles cfgo_irdy may wait for cfgo_trdy; 1..65535
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- addr  in  16  TV80 address; only [7:0] decoded
- cd_wdata  in  8  TV80 write data
- cd_rdata  out  8  read data for window hits, 0 otherwise
- mreq_n, iorq_n, rd_n, wr_n  in  1 each  TV80 strobes
- cfgo_wait_n  out  1  TV80 wait, low stalls CPU
- cfgo_irdy  out  1  transaction request
- cfgo_trdy  in  1  target completion
- cfgo_addr  out  AW  transaction address
- cfgo_write  out  1  1 = write, 0 = read; valid with cfgo_irdy
- cfgo_wr_data  out  DW  write data
- cfgo_rd_data  in  DW  read data, sampled when cfgo_irdy & cfgo_trdy
- cfgo_err  out  1  copy of sticky timeout flag

## Operation
- hit = !iorq_n & mreq_n & (!rd_n | !wr_n) & addr[7:4]==io_base_addr[7:4]; off = addr[3:0].
- Map: off 0..DW/8-1 = data bytes of DW-bit hold register (off 0 = LSB); off 8..8+AW/8-1 = address bytes (off 8 = LSB); off 12 = status; all other offsets read 0, writes ignored.
- Status: bit0 busy (FSM not IDLE), bit1 timeout (sticky, write 1 clears), bit7 autoinc (see Configuration), others 0.
- One-shot guard: flag `done` set on the edge an access completes, cleared when hit deasserts; register writes and launches happen only when hit & !done.
- FSM states IDLE, WRITE, READ, ACK; reset to IDLE.
- IDLE: write to off DW/8-1 updates that byte and goes WRITE (posted). Read of off 0 goes READ. All other accesses complete in IDLE.
- WRITE: cfgo_irdy=1, cfgo_write=1; on cfgo_trdy -> IDLE.
- READ: cfgo_irdy=1, cfgo_write=0; on cfgo_trdy load hold <= cfgo_rd_data, -> ACK.
- ACK: cd_rdata = hold[7:0]; -> IDLE next edge.
- Timeout: counter cleared on entry to WRITE/READ, increments each cycle without cfgo_trdy; at TIMEOUT cycles set timeout flag, drop request; WRITE -> IDLE; READ -> ACK with hold all ones.
- cfgo_wait_n low when hit & !done & (FSM not IDLE, or read of off 0 in IDLE); high in ACK for read of off 0. Writes to hold or address while busy are stalled, never dropped.
- trdy and timeout on same edge: trdy wins, no error.

## Timing
- Reset values: cfgo_irdy 0, cfgo_write 0, cfgo_addr 0, cfgo_wr_data 0, hold 0, cd_rdata 0, cfgo_err 0, cfgo_wait_n 1.
- cfgo_irdy rises the cycle after the launching edge; falls the cycle after the trdy or timeout edge.
- Read with trdy on first irdy cycle: cfgo_wait_n low 2 cycles, then high in ACK.
- Write launch: no stall; next window access stalls until IDLE.
- cfgo_wait_n, cd_rdata combinational from hit, off, state; everything else registered.
- Reset mid-transaction: irdy drops next cycle, FSM IDLE, flags cleared; late cfgo_trdy ignored.

## Configuration
- LCFG_CFGO_AUTOINC_EN defined: status bit7 is R/W autoinc; when 1, each trdy-completed transaction adds DW/8 to address register, wrapping modulo 2^AW; no increment on timeout.
- Undefined: bit7 reads 0, writes ignored, address changes only by CPU writes.

## Test plan
- DW=32, AW=16: write 0x34,0x12 to off 8,9, 0xDDCCBBAA to off 0..3 -> one cycle irdy/write, cfgo_addr 0x1234, cfgo_wr_data 0xDDCCBBAA.
- Read off 0, target returns 0x87654321 after 3 cycles -> wait_n low 4 cycles, cd_rdata 0x21; reads off 1..3 give 0x43,0x65,0x87 with no stall.
- Target never responds, TIMEOUT=16 -> irdy high 16 cycles, off 12 reads 0x02, cfgo_err 1, off 0 reads 0xFF; write 0x02 to off 12 clears.
- Write off 3 then immediately off 8 -> second access stalled until trdy, then applied once.
- LCFG_CFGO_AUTOINC_EN, bit7 set, addr 0xFFFC, two writes -> cfgo_addr 0xFFFC then 0x0000.
- Reset during READ -> irdy 0 next cycle, status 0x00, cfgo_trdy afterwards ignored.
